// File: rtl/vrp_req_fifo_if.sv
// ----------------------------------------------------------------------------
// vrp_req_fifo_if
//
// Purpose:
//   Handshake bundle around one per-requester request FIFO. The upstream side
//   (in_*) carries requests into the buffer; the downstream side (out_*) is the
//   head of the buffer as seen by one input lane of the round-robin arbiter.
//
// Parameters:
//   pack_pld : payload type, identical to the arbiter lane payload type.
//
// Signals:
//   in_vld  : upstream request valid
//   in_rdy  : FIFO can accept this cycle
//   in_pld  : upstream payload
//   out_vld : head entry valid (arbiter v_in_vld bit)
//   out_rdy : arbiter grant/ready for this lane
//   out_pld : head payload
//
// Modports:
//   master : environment view (drives requests, drives lane ready)
//   slave  : FIFO view (accepts requests, presents the head entry)
// ----------------------------------------------------------------------------
interface vrp_req_fifo_if #(
  parameter type pack_pld = logic
);

  logic    in_vld;
  logic    in_rdy;
  pack_pld in_pld;
  logic    out_vld;
  logic    out_rdy;
  pack_pld out_pld;

  modport master (
    output in_vld,
    input  in_rdy,
    output in_pld,
    input  out_vld,
    output out_rdy,
    input  out_pld
  );

  modport slave (
    input  in_vld,
    output in_rdy,
    input  in_pld,
    output out_vld,
    input  out_rdy,
    output out_pld
  );

endinterface : vrp_req_fifo_if

// File: rtl/vrp_req_fifo.sv
// ----------------------------------------------------------------------------
// vrp_req_fifo
//
// Purpose:
//   Per-requester request buffer on the L1D arbitration path. It absorbs bursts
//   from one requester and presents a steady valid/ready stream to one lane of
//   the round-robin arbiter. It is a synchronous circular FIFO with
//   extra-wrap-bit pointers, a registered occupancy counter and a registered
//   almost-full flag for upstream throttling.
//
// Optional feature (compile-time macro):
//   VRP_REQ_FIFO_BYPASS_EN
//     defined   : same-cycle bypass. When the FIFO is empty, an incoming
//                 request is shown directly on the output. If the lane is
//                 ready in that cycle the request passes through without being
//                 stored; otherwise it is written as a normal push.
//     undefined : purely registered output; a pushed entry becomes visible the
//                 cycle after it was written.
//
// Parameters:
//   pack_pld : payload type
//   DEPTH    : number of entries, power of two, >= 2
//   AF_LEVEL : almost_full threshold (count >= AF_LEVEL), 1..DEPTH
//
// Ports:
//   clk         : sole clock, rising edge
//   rst         : synchronous active-high reset
//   bus         : vrp_req_fifo_if.slave handshake bundle (in_* / out_*)
//   count       : current occupancy 0..DEPTH (registered)
//   almost_full : count >= AF_LEVEL (registered)
// ----------------------------------------------------------------------------
module vrp_req_fifo #(
  parameter type pack_pld = logic,
  parameter int  DEPTH    = 4,
  parameter int  AF_LEVEL = DEPTH - 1,
  localparam int PTR_W    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  vrp_req_fifo_if.slave    bus,
  output logic [PTR_W:0]   count,
  output logic             almost_full
);

  // Threshold expressed in the counter width so the compare is width-exact.
  localparam logic [PTR_W:0] AF_THRESH = (PTR_W + 1)'(AF_LEVEL);
  localparam logic [PTR_W:0] PTR_ONE   = (PTR_W + 1)'(1);

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  // Pointers carry one extra wrap bit: low PTR_W bits index the array, the MSB
  // distinguishes full from empty when the indices coincide.
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic [PTR_W:0]   count_nxt;
  logic             almost_full_nxt;

  // Storage array; deliberately not reset, only the pointers define validity.
  pack_pld          mem [DEPTH];

  // --------------------------------------------------------------------------
  // Derived status
  // --------------------------------------------------------------------------
  logic             empty;
  logic             full;
  logic             push;
  logic             pop;
  logic             bypass;
  logic [PTR_W-1:0] wr_idx;
  logic [PTR_W-1:0] rd_idx;

  assign wr_idx = wr_ptr[PTR_W-1:0];
  assign rd_idx = rd_ptr[PTR_W-1:0];

  assign empty  = (wr_ptr == rd_ptr);
  assign full   = (wr_idx == rd_idx) && (wr_ptr[PTR_W] != rd_ptr[PTR_W]);

  // Ready depends only on registered state and reset, never on out_rdy, so a
  // full FIFO cannot take a new entry in the same cycle it is popped.
  assign bus.in_rdy = !full && !rst;

`ifdef VRP_REQ_FIFO_BYPASS_EN
  // When empty, the incoming request is presented directly at the head.
  assign bus.out_vld = !empty || bus.in_vld;
  assign bus.out_pld = empty ? bus.in_pld : mem[rd_idx];

  // Pass-through: empty, request present and lane ready. The request is
  // consumed by the arbiter this cycle and never touches the storage.
  assign bypass = empty && bus.in_vld && bus.out_rdy;
`else
  assign bus.out_vld = !empty;
  assign bus.out_pld = mem[rd_idx];
  assign bypass      = 1'b0;
`endif

  // Storage-level transfers. A bypassed request is neither written nor read.
  assign push = bus.in_vld && bus.in_rdy && !bypass;
  assign pop  = bus.out_rdy && !empty;

  // --------------------------------------------------------------------------
  // Next-state occupancy and almost-full
  // --------------------------------------------------------------------------
  // Occupancy update: +1 on push only, -1 on pop only, hold otherwise.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + PTR_ONE;
      2'b01:   count_nxt = count - PTR_ONE;
      2'b11:   count_nxt = count;
      2'b00:   count_nxt = count;
      default: count_nxt = count;
    endcase
  end

  // Almost-full is registered from the next-state count so it lines up with
  // the count register in the same cycle.
  always_comb begin
    almost_full_nxt = 1'b0;
    if (count_nxt >= AF_THRESH) begin
      almost_full_nxt = 1'b1;
    end else begin
      almost_full_nxt = 1'b0;
    end
  end

  // --------------------------------------------------------------------------
  // Sequential state
  // --------------------------------------------------------------------------
  // Pointer, occupancy and almost-full registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      almost_full <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_ONE;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
      end
      count       <= count_nxt;
      almost_full <= almost_full_nxt;
    end
  end

  // Storage write port; push is already suppressed while rst is high.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_idx] <= bus.in_pld;
    end
  end

endmodule : vrp_req_fifo

// File: doc/vrp_req_fifo.md
# vrp_req_fifo

Per-requester request buffer for the L1D arbitration path. Each requester has one instance, which absorbs bursts and presents a steady valid/ready stream to one input lane of the round-robin arbiter. It is a synchronous circular FIFO with registered occupancy and an almost-full indication for upstream throttling. An optional same-cycle bypass is available for latency-critical lanes.

## Interface
Parameters:
- pack_pld, logic: payload type, identical to the arbiter lane payload type.
- DEPTH, 4: number of entries; a power of two, ≥2.
- AF_LEVEL, DEPTH-1: almost_full asserts when count ≥ AF_LEVEL; legal range 1..DEPTH.
- localparam PTR_W = $clog2(DEPTH): entry index width; pointers carry one extra wrap bit.

Ports:
- clk, input, 1: sole clock; all state updates on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- in_vld, input, 1: upstream request valid.
- in_rdy, output, 1: FIFO can accept this cycle.
- in_pld, input, pack_pld: upstream payload.
- out_vld, output, 1: head entry valid; connects to an arbiter v_in_vld bit.
- out_rdy, input, 1: arbiter grant/ready for this lane.
- out_pld, output, pack_pld: head payload.
- count, output, PTR_W+1: current occupancy, 0..DEPTH.
- almost_full, output, 1: count ≥ AF_LEVEL.

## Operation
- Push = in_vld && in_rdy. Pop = out_vld && out_rdy. Transfers happen only on these handshakes.
- Storage: DEPTH×pack_pld array. wr_ptr and rd_ptr are PTR_W+1 bits wide. The low PTR_W bits index the array, and the pointers wrap naturally modulo 2·DEPTH.
- empty = (wr_ptr == rd_ptr). full = (low bits equal) && (MSBs differ).
- in_rdy = !full && !rst. It has no combinational dependency on out_rdy, so a push cannot be accepted in the same cycle as a pop when the FIFO is full.
- out_vld = !empty. out_pld = mem[rd_ptr low bits]. out_pld is don't-care while out_vld = 0.
- On push, write mem[wr_ptr] and increment wr_ptr. On pop, increment rd_ptr. Both may happen in one cycle.
- count is a register: +1 on push only, −1 on pop only, unchanged on both or neither. It must always equal wr_ptr − rd_ptr.
- almost_full is registered, computed from the next-state count.
- Once out_vld is asserted, out_vld and out_pld hold stable until popped. A pending head is never withdrawn.
- Storage array is not reset.

## Timing
- Reset values: wr_ptr = 0, rd_ptr = 0, count = 0, out_vld = 0, almost_full = 0. in_rdy = 0 while rst = 1 and 1 on the first cycle after rst deasserts.
- Latency, bypass off: a push at edge N gives out_vld = 1 in the cycle after edge N. Minimum fill-to-drain is 1 cycle.
- Full-rate throughput: one push and one pop per cycle when neither full nor empty.
- Full (count = DEPTH): in_rdy = 0. A pop in this cycle frees space, and in_rdy = 1 the following cycle.
- Empty with push and out_rdy = 1 (bypass off): a push occurs but no pop, since out_vld = 0. The entry becomes visible next cycle.
- Wrap-around: pointers roll from 2·DEPTH−1 to 0 with no bubble.
- Reset mid-operation: all contents are discarded in the reset cycle. out_vld = 0 the cycle after rst is sampled, regardless of the prior count.

## Configuration
- VRP_REQ_FIFO_BYPASS_EN defined (bypass on):
  - out_vld = !empty || in_vld.
  - out_pld = empty ? in_pld : mem[rd_ptr].
  - When empty && in_vld && out_rdy, the request passes through in the same cycle. Nothing is written, and the pointers and count stay unchanged.
  - When empty && in_vld && !out_rdy, the request is written normally.
  - in_rdy is unchanged: !full && !rst.
- VRP_REQ_FIFO_BYPASS_EN undefined (bypass off): purely registered output, per Operation/Timing. Zero-cycle pass-through is impossible.

## Test plan
- Reset/fill, DEPTH=4: hold rst 2 cycles, then push A,B,C,D on consecutive cycles with out_rdy = 0. Required: count = 1,2,3,4; almost_full = 1 once count = 3; in_rdy = 0 after the 4th push; then pop four times with out_pld = A,B,C,D in order.
- Streaming: in_vld = out_rdy = 1 for 20 cycles with incrementing payload 0..19. Required: after 1-cycle fill, one pop per cycle, in-order 0..19, count stays at 1, with pointer wrap exercised.
- Full with simultaneous pop: at count = 4, hold in_vld = 1 and out_rdy = 1. Required: in_rdy = 0 that cycle, count = 3 next cycle, in_rdy = 1, and the push is accepted the cycle after.
- Backpressure stability: head = 0x5A, out_rdy = 0 for 5 cycles with random in_vld. Required: out_vld = 1 and out_pld = 0x5A are constant throughout.
- Mid-operation reset: at count = 3, assert rst for 1 cycle. Required: count = 0, out_vld = 0, almost_full = 0 next cycle, and the stale entries never reappear.
- Bypass, macro defined: FIFO empty, in_vld = 1, in_pld = 0x33, out_rdy = 1. Required: out_vld = 1 and out_pld = 0x33 in the same cycle, count stays 0. With the macro undefined, the same stimulus gives out_vld = 0 that cycle and out_vld = 1 (0x33) the next.
